// File: rtl/mii_rx_framer.sv
// MII receive framer: hunts preamble/SFD, assembles nibbles into bytes and emits
// them through a one-byte hold buffer so the last byte can be tagged with eof.
`default_nettype none

module mii_rx_framer #(
  parameter int BIT_REVERSE    = 1,
  parameter int STRIP_PREAMBLE = 1,
  parameter int MAX_LEN        = 1518,
  parameter int LEN_W          = 11
) (
  input  logic             mii_clk,
  input  logic             reset,
  input  logic             mii_dv,
  input  logic             mii_er,
  input  logic [3:0]       mii_d,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic [LEN_W-1:0] frame_len
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t           state, state_nx;
  logic [3:0]       nib, low, low_nx;
  logic             phase, phase_nx;
  logic             seen5, seen5_nx;
  logic [7:0]       hold, hold_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic             err, err_nx;
  logic             valid_nx, sof_nx, eof_nx, oerr_nx;
  logic [7:0]       data_nx;
  logic [LEN_W-1:0] len_nx;

  assign nib = (BIT_REVERSE != 0) ? {mii_d[0], mii_d[1], mii_d[2], mii_d[3]} : mii_d;

  always_comb begin
    state_nx = state;
    low_nx   = low;
    phase_nx = phase;
    seen5_nx = seen5;
    hold_nx  = hold;
    cnt_nx   = cnt;
    err_nx   = err;
    valid_nx = 1'b0;
    sof_nx   = 1'b0;
    eof_nx   = 1'b0;
    oerr_nx  = 1'b0;
    data_nx  = out_data;
    len_nx   = frame_len;
    case (state)
      IDLE: begin
        phase_nx = 1'b0;
        cnt_nx   = '0;
        err_nx   = 1'b0;
        seen5_nx = 1'b0;
        if (mii_dv) begin
          if (STRIP_PREAMBLE != 0) begin
            state_nx = PREAMBLE;
          end else begin
            state_nx = DATA;
            low_nx   = nib;
            phase_nx = 1'b1;
            err_nx   = mii_er;
          end
        end
      end
      PREAMBLE: begin
        if (!mii_dv)                     state_nx = IDLE;
        else if (nib == 4'h5)            seen5_nx = 1'b1;
        else if (nib == 4'hD && seen5)   state_nx = DATA;
        else                             state_nx = DROP;
      end
      DATA: begin
        if (!mii_dv) begin
          // Frame end: flush the held byte; a dangling low nibble is an alignment error.
          state_nx = IDLE;
          if (cnt != '0) begin
            valid_nx = 1'b1;
            data_nx  = hold;
            sof_nx   = (cnt == ONE);
            eof_nx   = 1'b1;
            oerr_nx  = err | phase;
            len_nx   = cnt;
          end
        end else begin
          if (mii_er) err_nx = 1'b1;
          if (!phase) begin
            low_nx   = nib;
            phase_nx = 1'b1;
          end else begin
            phase_nx = 1'b0;
            if (cnt == MAX_CNT) begin
              state_nx = DROP;
              valid_nx = 1'b1;
              data_nx  = hold;
              sof_nx   = (cnt == ONE);
              eof_nx   = 1'b1;
              oerr_nx  = 1'b1;
              len_nx   = cnt;
            end else begin
              hold_nx = {nib, low};
              cnt_nx  = cnt + ONE;
              if (cnt != '0) begin
                valid_nx = 1'b1;
                data_nx  = hold;
                sof_nx   = (cnt == ONE);
              end
            end
          end
        end
      end
      default: begin
        if (!mii_dv) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge mii_clk) begin
    if (reset) begin
      // A frame already in flight at reset is dropped rather than emitted.
      state     <= mii_dv ? DROP : IDLE;
      low       <= '0;
      phase     <= 1'b0;
      seen5     <= 1'b0;
      hold      <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= '0;
      frame_len <= '0;
    end else begin
      state     <= state_nx;
      low       <= low_nx;
      phase     <= phase_nx;
      seen5     <= seen5_nx;
      hold      <= hold_nx;
      cnt       <= cnt_nx;
      err       <= err_nx;
      out_valid <= valid_nx;
      out_sof   <= sof_nx;
      out_eof   <= eof_nx;
      out_err   <= oerr_nx;
      out_data  <= data_nx;
      frame_len <= len_nx;
    end
  end

endmodule

`default_nettype wire

// File: doc/mii_rx_framer.md
MII_RX_FRAMER -- requirements
Module: mii_rx_framer

Interface
REQ-001 SHALL have parameter BIT_REVERSE, default 1, meaning each mii_d nibble is mapped as n={mii_d[0],mii_d[1],mii_d[2],mii_d[3]}; 0 means n=mii_d.
REQ-002 SHALL have parameter STRIP_PREAMBLE, default 1, meaning preamble/SFD is hunted and removed; 0 means bytes start at the first nibble with mii_dv high.
REQ-003 SHALL have parameter MAX_LEN, default 1518, meaning maximum payload bytes per frame.
REQ-004 SHALL have parameter LEN_W, default 11, meaning frame_len width; MAX_LEN+1 < 2^LEN_W.
REQ-005 SHALL have ports: mii_clk in 1, receive clock, all logic on its rising edge.
REQ-006 SHALL have ports: reset in 1, synchronous active-high reset.
REQ-007 SHALL have ports: mii_dv in 1, data valid; mii_er in 1, receive error; mii_d in 4, receive nibble.
REQ-008 SHALL have ports: out_valid out 1, one-cycle byte strobe; out_data out 8, byte; out_sof out 1, first byte of frame; out_eof out 1, last byte of frame.
REQ-009 SHALL have ports: out_err out 1, frame error, meaningful with out_eof; frame_len out LEN_W, byte count, meaningful with out_eof.

Function
REQ-010 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-011 IDLE: mii_dv=1 SHALL go to PREAMBLE if STRIP_PREAMBLE=1, else to DATA with that nibble taken as a low nibble.
REQ-012 PREAMBLE: n=0x5 SHALL stay; n=0xD after at least one 0x5 SHALL go to DATA (SFD, not emitted); any other n SHALL go to DROP; mii_dv=0 SHALL go to IDLE with no output.
REQ-013 DATA: nibbles SHALL alternate low then high; byte = {high n, low n}.
REQ-014 Each completed byte SHALL be held in a one-byte buffer; the previously held byte SHALL then be emitted with out_valid=1 for exactly one cycle, registered on the edge after the completing high nibble.
REQ-015 The first emitted byte of a frame SHALL carry out_sof=1.
REQ-016 mii_dv=0 sampled in DATA SHALL emit the held byte on the next cycle with out_eof=1, then go to IDLE; a one-byte frame SHALL have out_sof=out_eof=1 on the same strobe.
REQ-017 mii_dv=0 in DATA with no completed byte SHALL produce no output and go to IDLE.
REQ-018 A dangling low nibble at mii_dv=0 SHALL be discarded and SHALL set out_err on the eof byte (alignment error).
REQ-019 mii_er=1 sampled while in DATA with mii_dv=1 SHALL set a sticky error reported as out_err=1 on the eof byte.
REQ-020 frame_len SHALL equal the number of bytes emitted in the frame, including the eof byte, valid only when out_eof=1.
REQ-021 When a byte would be completed while MAX_LEN bytes have already been completed, the held byte SHALL be emitted with out_eof=1, out_err=1, frame_len=MAX_LEN; then DROP.
REQ-022 DROP: SHALL emit nothing until mii_dv=0 is sampled, then IDLE.
REQ-023 out_sof, out_eof, out_err SHALL be 0 whenever out_valid=0; out_data and frame_len SHALL hold their last value.

Reset
REQ-024 Reset SHALL drive out_valid, out_sof, out_eof, out_err to 0, out_data to 0x00, frame_len to 0, and clear the byte counter, error flag and nibble phase.
REQ-025 After reset, state SHALL be DROP if mii_dv=1 and IDLE otherwise, so a frame in progress at reset is never emitted.
REQ-026 Reset SHALL take precedence over all other inputs on the same edge.

Verification
REQ-027 Defaults: 15 nibbles 0x5, then 0xD, then bytes 0x01,0x02,0x03 (mapped, low nibble first), then mii_dv=0 -> 3 strobes 0x01(sof),0x02,0x03(eof), out_err=0, frame_len=3.
REQ-028 Odd nibble: as REQ-027 plus one extra nibble before mii_dv=0 -> eof byte 0x03, out_err=1, frame_len=3.
REQ-029 Preamble corruption: 0x5,0x5,0x7,... -> no out_valid until after mii_dv falls; the next good frame is received normally.
REQ-030 Oversize: MAX_LEN=4, 6-byte payload -> 4 strobes, 4th with out_eof=1, out_err=1, frame_len=4; no further strobes for that frame.
REQ-031 STRIP_PREAMBLE=0, BIT_REVERSE=0: mii_d 0x4,0x3 then mii_dv=0 -> one strobe 0x34 with sof=eof=1, frame_len=1; with mii_er=1 on a nibble -> out_err=1.
REQ-032 Reset asserted mid-DATA with mii_dv still high -> all outputs 0, no strobes until mii_dv falls and a new frame starts.
